bf16_accum_seq: RTL and testbench

Sequencing accumulator that sits directly around the `fadd` bfloat16 adder. It accepts a stream of bf16 operands over a valid/ready handshake and drives `fadd` with the running sum and each new operand. It waits for `fadd` to signal completion, captures the result, and emits one reduced bf16 sum per group, where a group is terminated by `in_last`. It is both the upstream feeder of `fadd` (a/b) and the downstream consumer of its `sum`/`ready`.

---
 rtl/bf16_pkg.sv | 21 ++
 rtl/bf16_accum_seq.sv | 145 ++++++++++++++
 tb/tb_bf16_accum_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 types, sequencer state encoding and special constants
// for the bf16 accumulation path.
package bf16_pkg;

    typedef logic [15:0] bf16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam bf16_t BF16_POS_ZERO = 16'h0000;
    localparam bf16_t BF16_QNAN     = 16'h7FC0;

    // True for +0 and -0; the sign bit is ignored.
    function automatic logic bf16_is_zero(input bf16_t x);
        return (x[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/bf16_accum_seq.sv
// Group-wise bf16 reduction sequencer wrapped around an external fadd unit.
// Optional feature: BF16_ACC_ZERO_BYPASS_EN lets +/-0 operands skip the adder.
module bf16_accum_seq
    import bf16_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    input  logic             out_ready,
    output logic [15:0]      fadd_a,
    output logic [15:0]      fadd_b,
    input  logic [15:0]      fadd_sum,
    input  logic             fadd_ready
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    acc_state_t        state_reg, state_next;
    bf16_t             acc_reg;
    bf16_t             b_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              err_reg;
    logic              last_reg;
    logic              seen_low_reg;
    logic [TW-1:0]     timer_reg;

    logic accept;
    logic complete;
    logic timed_out;
    logic skip;

    assign accept    = in_valid && in_ready;
    // Only a rising edge of fadd_ready counts; a level left over from the
    // previous operand must first drop.
    assign complete  = fadd_ready && seen_low_reg;
    assign timed_out = (timer_reg == TW'(TIMEOUT - 1)) && !complete;

`ifdef BF16_ACC_ZERO_BYPASS_EN
    assign skip = bf16_is_zero(in_data);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (skip) begin
                        state_next = in_last ? DONE : IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (complete || timed_out) begin
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        out_data  = acc_reg;
        out_count = cnt_reg;
        out_err   = err_reg;
        fadd_a    = acc_reg;
        fadd_b    = b_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg      <= BF16_POS_ZERO;
            b_reg        <= BF16_POS_ZERO;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            last_reg     <= 1'b0;
            seen_low_reg <= 1'b0;
            timer_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (cnt_reg != {CNT_W{1'b1}}) begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                        // A skipped zero leaves fadd_b untouched so the adder sees no new work.
                        if (!skip) begin
                            b_reg        <= in_data;
                            last_reg     <= in_last;
                            seen_low_reg <= 1'b0;
                            timer_reg    <= '0;
                        end
                    end
                end
                WAIT: begin
                    seen_low_reg <= seen_low_reg | ~fadd_ready;
                    timer_reg    <= timer_reg + TW'(1);
                    if (complete) begin
                        acc_reg <= fadd_sum;
                    end else if (timed_out) begin
                        acc_reg <= BF16_QNAN;
                        err_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_reg <= BF16_POS_ZERO;
                        cnt_reg <= '0;
                        err_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_accum_seq.sv
// Directed bench for bf16_accum_seq with a behavioural fadd model
// (ready drops on any a/b change and returns 3 cycles later with the sum).
module tb_bf16_accum_seq;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = 16'h0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
    logic             out_ready = 1'b0;
    logic [15:0]      fadd_a;
    logic [15:0]      fadd_b;
    logic [15:0]      fadd_sum;
    logic             fadd_ready;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_accept = 0;
    int t_out = 0;

    bf16_accum_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .out_err(out_err), .out_ready(out_ready),
        .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_sum(fadd_sum), .fadd_ready(fadd_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Exact sums for the operand pairs this bench uses; NaN in a propagates.
    function automatic logic [15:0] fsum(input logic [15:0] a, input logic [15:0] b);
        if (a[14:7] == 8'hFF && a[6:0] != 7'd0) return a;
        case ({a, b})
            32'h0000_3F80: return 16'h3F80;
            32'h3F80_3FC0: return 16'h4020;
            32'h3F80_BF80: return 16'h0000;
            32'h0000_3FC0: return 16'h3FC0;
            32'h0000_4000: return 16'h4000;
            32'h0000_0000: return 16'h0000;
            32'h0000_8000: return 16'h0000;
            default:       return 16'hDEAD;
        endcase
    endfunction

    logic [31:0] m_prev;
    int          m_cnt;
    logic        m_rdy;
    logic [15:0] m_sum;
    bit          hold_low = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_prev <= {fadd_a, fadd_b};
            m_rdy  <= 1'b1;
            m_cnt  <= 0;
            m_sum  <= 16'h0;
        end else if ({fadd_a, fadd_b} != m_prev) begin
            m_prev <= {fadd_a, fadd_b};
            m_rdy  <= 1'b0;
            m_cnt  <= 3;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_rdy <= 1'b1;
                m_sum <= fsum(m_prev[31:16], m_prev[15:0]);
            end
        end
    end

    assign fadd_sum   = m_sum;
    assign fadd_ready = hold_low ? 1'b0 : m_rdy;

    bit          track_b = 1'b0;
    logic [15:0] pb;
    int          bchg = 0;
    always @(negedge clock) begin
        if (track_b) begin
            if (fadd_b != pb) bchg = bchg + 1;
            pb = fadd_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("send_wait", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        last_accept = cyc;
        $display("IN   data=%h last=%0d cyc=%0d", d, l, cyc);
    endtask

    task automatic get_result(input string tag, input logic [15:0] d, input int c,
                              input logic e, input bit stall);
        int n;
        @(negedge clock);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        t_out = cyc;
        $display("OUT  %s data=%h count=%0d err=%0d cyc=%0d", tag, out_data, out_count, out_err, cyc);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_err"},   32'(out_err),   32'(e));
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"},  32'(out_data),  32'(d));
                check({tag, "_hold_inrdy"}, 32'(in_ready),  32'd0);
            end
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check({tag, "_clr_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_clr_count"}, 32'(out_count), 32'd0);
        check({tag, "_clr_err"},   32'(out_err),   32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_out_err"},   32'(out_err),   32'd0);
        check({tag, "_fadd_a"},    32'(fadd_a),    32'd0);
        check({tag, "_fadd_b"},    32'(fadd_b),    32'd0);
    endtask

    int t0;

    initial begin
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_vals("rst");
        repeat (4) @(negedge clock);

        // 1.0 + 1.5 = 2.5, with a 5-cycle stalled result
        send(16'h3F80, 1'b0);
        send(16'h3FC0, 1'b1);
        get_result("g_add", 16'h4020, 2, 1'b0, 1'b1);
        repeat (6) @(negedge clock);

        // 1.0 + -1.0 = +0
        send(16'h3F80, 1'b0);
        send(16'hBF80, 1'b1);
        get_result("g_cancel", 16'h0000, 2, 1'b0, 1'b0);
        repeat (6) @(negedge clock);

        // adder never completes: qNaN and err after TIMEOUT wait cycles
        hold_low = 1'b1;
        send(16'h3F80, 1'b1);
        t0 = last_accept;
        get_result("g_tmo", 16'h7FC0, 1, 1'b1, 1'b0);
        check("g_tmo_cycles", 32'(t_out - t0), 32'(TIMEOUT));
        hold_low = 1'b0;
        repeat (8) @(negedge clock);
        send(16'h3FC0, 1'b1);
        get_result("g_after_tmo", 16'h3FC0, 1, 1'b0, 1'b0);
        repeat (6) @(negedge clock);

        // reset during the wait of the second operand
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_vals("midrst");
        repeat (8) @(negedge clock);
        send(16'h4000, 1'b1);
        get_result("g_post_rst", 16'h4000, 1, 1'b0, 1'b0);
        repeat (8) @(negedge clock);

        // zero operands: bypassed when the feature is built in
        pb      = fadd_b;
        bchg    = 0;
        track_b = 1'b1;
        send(16'h0000, 1'b0);
        t0 = last_accept;
        send(16'h8000, 1'b0);
        send(16'h3F80, 1'b1);
        get_result("g_zero", 16'h3F80, 3, 1'b0, 1'b0);
        track_b = 1'b0;
`ifdef BF16_ACC_ZERO_BYPASS_EN
        check("g_zero_cycles", 32'(t_out - t0), 32'd7);
        check("g_zero_bchg",   32'(bchg),       32'd1);
`else
        check("g_zero_cycles", 32'(t_out - t0), 32'd17);
        check("g_zero_bchg",   32'(bchg),       32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
